bit_multiplier: RTL and testbench
=================================

// Module: bit_multiplier
// PURPOSE
//   Unsigned/signed multiplier; default configuration is a 1-bit multiplier (prod = a AND b).
//   Provides a combinational product output plus an optional registered, valid-tagged copy
//   for use in pipelined datapaths. Leaf arithmetic block; no handshake back-pressure.
//   One clock; reset is synchronous and active-low (clk, rst_n).
// PARAMETERS
//   WIDTH        1  operand width in bits (>=1)
//   SIGNED       0  0 = unsigned operands, 1 = two's-complement operands
//   PIPE_STAGES  1  register stages on prod_q/out_valid path (0..4); 0 = prod_q combinational
// PORTS
//   clk        in   1        rising-edge clock
//   rst_n      in   1        synchronous active-low reset
//   a          in   WIDTH    multiplicand
//   b          in   WIDTH    multiplier
//   prod       out  PW       combinational product; PW = 1 if WIDTH==1, else 2*WIDTH
//   in_valid   in   1        qualifies a/b for the registered path
//   prod_q     out  PW       registered product, PIPE_STAGES cycles after capture
//   out_valid  out  1        prod_q valid strobe, in_valid delayed PIPE_STAGES cycles
// BEHAVIOUR
//   - prod is purely combinational: prod = a * b, full-precision, no clock or reset dependency;
//     settles within one delta of any a/b change; stable regardless of rst_n or in_valid.
//   - WIDTH==1: prod = a & b (00->0, 10->0, 01->0, 11->1); SIGNED ignored for WIDTH==1.
//   - WIDTH>1, SIGNED=0: zero-extend operands to 2*WIDTH, multiply, no truncation/overflow.
//   - WIDTH>1, SIGNED=1: sign-extend to 2*WIDTH; (-2^(W-1))*(-2^(W-1)) = +2^(2W-2), fits in PW.
//   - X/Z on a or b: prod may be X; no X-masking required.
//   - Registered path: pipeline of PIPE_STAGES stages, each holding {valid, product}.
//     Stage 0 captures {in_valid, a*b} every rising clk edge (product captured even if
//     in_valid=0; only valid bit gates meaning). Stage k captures stage k-1.
//   - Latency: out_valid/prod_q reflect in_valid/a/b sampled exactly PIPE_STAGES edges earlier.
//     Throughput one product per cycle; back-to-back in_valid fully supported.
//   - PIPE_STAGES=0: prod_q = prod, out_valid = in_valid (combinational, reset not applied).
//   - Reset (rst_n=0 at rising edge): all stage valid bits and product registers clear to 0;
//     so out_valid=0 and prod_q=0 from the first edge with rst_n low until new data propagates.
//   - Reset mid-operation: in-flight results discarded, no out_valid for them; in_valid
//     sampled on the same edge as rst_n=0 is dropped.
//   - After reset release, first valid result appears PIPE_STAGES edges after first in_valid.
//   - No internal state besides the pipeline registers; no FSM.
// TESTING
//   - Default params, comb path: drive (a,b)=(0,0),(1,0),(0,1),(1,1), wait 10 ns each ->
//     prod = 0,0,0,1; any mismatch prints "erro" and ends sim.
//   - Reset: hold rst_n=0 for 2 clks with in_valid=1,a=b=1 -> out_valid=0, prod_q=0 throughout.
//   - Pipeline, PIPE_STAGES=1: release reset, in_valid=1 with a=b=1 for one cycle ->
//     next edge out_valid=1, prod_q=1; following cycle (in_valid=0) out_valid=0.
//   - WIDTH=8 SIGNED=0: a=255,b=255 -> prod=16'hFE01; a=0,b=200 -> prod=0.
//   - WIDTH=8 SIGNED=1: a=-128,b=-128 -> prod=16'h4000; a=-1,b=3 -> prod=16'hFFFD.
//   - PIPE_STAGES=3, stream 4 back-to-back valids, assert rst_n=0 after 2 edges ->
//     no out_valid emitted for any of the stream; outputs 0 on the edge reset is sampled.

Source files
------------

// File: rtl/bit_multiplier.sv
// bit_multiplier: full-precision unsigned/signed multiplier.
// Offers a purely combinational product plus a valid-tagged copy that travels
// through PIPE_STAGES register stages for use inside pipelined datapaths.
module bit_multiplier #(
  parameter int WIDTH       = 1,
  parameter int SIGNED      = 0,
  parameter int PIPE_STAGES = 1,
  localparam int PW         = (WIDTH == 1) ? 1 : 2 * WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [PW-1:0]    prod,
  input  logic             in_valid,
  output logic [PW-1:0]    prod_q,
  output logic             out_valid
);

  // Product core. A 1-bit multiply is just an AND, and signedness is
  // meaningless there. Wider operands are extended to the full product width
  // first, so the low PW bits of the extended multiply are the exact result
  // for both unsigned and two's-complement interpretations.
  if (WIDTH == 1) begin : g_bit
    assign prod = a & b;
  end else if (SIGNED != 0) begin : g_signed
    logic [PW-1:0] ext_a;
    logic [PW-1:0] ext_b;
    assign ext_a = {{WIDTH{a[WIDTH-1]}}, a};
    assign ext_b = {{WIDTH{b[WIDTH-1]}}, b};
    assign prod  = ext_a * ext_b;
  end else begin : g_unsigned
    logic [PW-1:0] ext_a;
    logic [PW-1:0] ext_b;
    assign ext_a = {{WIDTH{1'b0}}, a};
    assign ext_b = {{WIDTH{1'b0}}, b};
    assign prod  = ext_a * ext_b;
  end

  // Registered path. With zero stages the "registered" outputs simply mirror
  // the combinational ones and reset has no effect on them.
  if (PIPE_STAGES == 0) begin : g_no_pipe
    assign prod_q    = prod;
    assign out_valid = in_valid;
  end else begin : g_pipe
    logic          stage_valid [PIPE_STAGES];
    logic [PW-1:0] stage_prod  [PIPE_STAGES];

    // Shift {valid, product} down the pipe every edge; the product is captured
    // regardless of in_valid, and reset flushes every stage including the
    // sample presented on the reset edge.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int k = 0; k < PIPE_STAGES; k++) begin
          stage_valid[k] <= 1'b0;
          stage_prod[k]  <= '0;
        end
      end else begin
        stage_valid[0] <= in_valid;
        stage_prod[0]  <= prod;
        for (int k = 1; k < PIPE_STAGES; k++) begin
          stage_valid[k] <= stage_valid[k-1];
          stage_prod[k]  <= stage_prod[k-1];
        end
      end
    end

    assign prod_q    = stage_prod[PIPE_STAGES-1];
    assign out_valid = stage_valid[PIPE_STAGES-1];
  end

endmodule

// File: tb/tb_bit_multiplier.sv
// tb_bit_multiplier: exercises three configurations side by side:
//   1-bit / 1 stage (default), 8-bit unsigned / 0 stages, 8-bit signed / 3 stages.
// Expected values come from plain integer arithmetic and an edge-indexed
// history of what was presented, not from any register model.
module tb_bit_multiplier;

  localparam int HIST   = 4096;
  localparam int S_PIPE = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  // Default configuration
  logic a1, b1, iv1;
  logic p1, pq1, ov1;
  // 8-bit unsigned, combinational registered path
  logic [7:0]  ua, ub;
  logic        uv;
  logic [15:0] up, upq;
  logic        uov;
  // 8-bit signed, three stages
  logic [7:0]  sa, sb;
  logic        sv;
  logic [15:0] sp, spq;
  logic        sov;

  int n_cmp = 0;
  int n_bad = 0;
  int edge_n = 0;

  logic        hist_rst_n [HIST];
  logic        hist_v1    [HIST];
  logic        hist_p1    [HIST];
  logic        hist_sv    [HIST];
  logic [15:0] hist_sp    [HIST];

  bit_multiplier #(.WIDTH(1), .SIGNED(0), .PIPE_STAGES(1)) u_bit (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .prod(p1),
    .in_valid(iv1), .prod_q(pq1), .out_valid(ov1)
  );

  bit_multiplier #(.WIDTH(8), .SIGNED(0), .PIPE_STAGES(0)) u_uns (
    .clk(clk), .rst_n(rst_n), .a(ua), .b(ub), .prod(up),
    .in_valid(uv), .prod_q(upq), .out_valid(uov)
  );

  bit_multiplier #(.WIDTH(8), .SIGNED(1), .PIPE_STAGES(S_PIPE)) u_sgn (
    .clk(clk), .rst_n(rst_n), .a(sa), .b(sb), .prod(sp),
    .in_valid(sv), .prod_q(spq), .out_valid(sov)
  );

  // Free-running 10 ns clock
  always #5 clk = ~clk;

  function automatic logic [15:0] umul(input logic [7:0] x, input logic [7:0] y);
    int xi;
    int yi;
    xi = int'(x);
    yi = int'(y);
    return 16'(xi * yi);
  endfunction

  function automatic logic [15:0] smul(input logic [7:0] x, input logic [7:0] y);
    int xi;
    int yi;
    xi = $signed(x);
    yi = $signed(y);
    return 16'(xi * yi);
  endfunction

  // A sample taken at edge n-p+1 reaches the output after edge n only if no
  // reset was sampled at any edge in between (inclusive).
  function automatic bit pipe_alive(input int n, input int p);
    if (n - p + 1 < 0) return 1'b0;
    for (int e = n - p + 1; e <= n; e++) begin
      if (hist_rst_n[e] == 1'b0) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("[TB] FAIL %s observed=%h expected=%h (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  // Checks everything that depends only on the currently driven inputs
  task automatic checkComb();
    checkOutput("bit_prod", 16'(p1), 16'(a1 & b1));
    checkOutput("uns_prod", up, umul(ua, ub));
    checkOutput("sgn_prod", sp, smul(sa, sb));
    checkOutput("uns_prod_q_passthru", upq, umul(ua, ub));
    checkOutput("uns_out_valid_passthru", 16'(uov), 16'(uv));
  endtask

  // Checks the pipelined outputs after the edge just recorded
  task automatic checkPipes();
    bit alive;
    int src;
    alive = pipe_alive(edge_n, 1);
    checkOutput("bit_out_valid", 16'(ov1), alive ? 16'(hist_v1[edge_n]) : 16'h0);
    checkOutput("bit_prod_q", 16'(pq1), alive ? 16'(hist_p1[edge_n]) : 16'h0);
    alive = pipe_alive(edge_n, S_PIPE);
    src = edge_n - S_PIPE + 1;
    checkOutput("sgn_out_valid", 16'(sov), alive ? 16'(hist_sv[src]) : 16'h0);
    checkOutput("sgn_prod_q", spq, alive ? hist_sp[src] : 16'h0);
  endtask

  // One clock cycle: record what the edge samples, check pipe outputs, then
  // drive the next inputs and check the combinational results.
  task automatic applyStimulus(input logic r,
                               input logic v1, input logic x1, input logic y1,
                               input logic vu, input logic [7:0] xu, input logic [7:0] yu,
                               input logic vs, input logic [7:0] xs, input logic [7:0] ys);
    @(posedge clk);
    hist_rst_n[edge_n] = rst_n;
    hist_v1[edge_n]    = iv1;
    hist_p1[edge_n]    = a1 & b1;
    hist_sv[edge_n]    = sv;
    hist_sp[edge_n]    = smul(sa, sb);
    #1;
    checkPipes();
    edge_n++;
    rst_n = r;
    iv1 = v1; a1 = x1; b1 = y1;
    uv = vu;  ua = xu; ub = yu;
    sv = vs;  sa = xs; sb = ys;
    #1;
    checkComb();
  endtask

  // Directed sequence followed by a randomized soak
  initial begin
    rst_n = 1'b0;
    iv1 = 1'b1; a1 = 1'b1; b1 = 1'b1;
    uv = 1'b1;  ua = 8'd1; ub = 8'd1;
    sv = 1'b1;  sa = 8'd1; sb = 8'd1;
    #1;
    checkComb();
    checkOutput("bit_prod_in_reset", 16'(p1), 16'h1);

    // Held in reset with valid data presented: nothing may come out
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'd1, 8'd1, 1'b1, 8'd1, 8'd1);
    checkOutput("reset_ov1_low", 16'(ov1), 16'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'd255, 8'd255, 1'b0, 8'h80, 8'h80);
    checkOutput("reset_pq1_zero", 16'(pq1), 16'h0);
    checkOutput("uns_255x255", up, 16'hFE01);
    checkOutput("sgn_m128xm128", sp, 16'h4000);

    // Single valid pulse through the 1-stage path, then the 1-bit truth table
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd200, 1'b0, 8'hFF, 8'd3);
    checkOutput("first_valid_ov1", 16'(ov1), 16'h1);
    checkOutput("first_valid_pq1", 16'(pq1), 16'h1);
    checkOutput("uns_0x200", up, 16'h0000);
    checkOutput("sgn_m1x3", sp, 16'hFFFD);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd7, 8'd9, 1'b0, 8'd5, 8'd6);
    checkOutput("pulse_ends_ov1", 16'(ov1), 16'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd7, 8'd9, 1'b0, 8'd5, 8'd6);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd7, 8'd9, 1'b0, 8'd5, 8'd6);

    // Signed 3-stage: four back-to-back valids, reset sampled after two edges
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b1, 8'd10, 8'd11);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b1, 8'd12, 8'd13);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b1, 8'd14, 8'd15);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b1, 8'd16, 8'd17);
    checkOutput("flush_sov_on_reset_edge", 16'(sov), 16'h0);
    checkOutput("flush_spq_on_reset_edge", spq, 16'h0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 8'd0);
      checkOutput("flush_no_sov", 16'(sov), 16'h0);
    end

    // Randomized soak with occasional resets
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 24) != 0),
                    1'($urandom), 1'($urandom), 1'($urandom),
                    1'($urandom), 8'($urandom), 8'($urandom),
                    1'($urandom), 8'($urandom), 8'($urandom));
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h80, 8'h80, 1'b0, 8'h80, 8'h7F);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h7F, 8'h7F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
